// File: rtl/usb_pkg.sv
// usb_pkg: PID/sync constants, packet and FSM state types shared by the USB receive controller
package usb_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_IN    = 8'h96;
    localparam logic [7:0] PID_DATA0 = 8'h3C;
    localparam logic [7:0] PID_ACK   = 8'h2D;

    typedef enum logic [1:0] {PKT_NONE, PKT_TOKEN, PKT_DATA, PKT_HS} pkt_t;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_CHK_SYNC, S_PID, S_CHK_PID,
        S_CRC5, S_CRC16, S_DATA, S_WAIT_EOP, S_DONE, S_ERR
    } state_t;

    function automatic pkt_t pid_class(input logic [7:0] pid);
        return pid == PID_IN    ? PKT_TOKEN :
               pid == PID_DATA0 ? PKT_DATA  :
               pid == PID_ACK   ? PKT_HS    : PKT_NONE;
    endfunction

    // bits per field; zero outside the field states
    function automatic logic [6:0] field_bits(input state_t s);
        return s == S_SYNC  ? 7'd8  :
               s == S_PID   ? 7'd8  :
               s == S_CRC5  ? 7'd5  :
               s == S_CRC16 ? 7'd16 :
               s == S_DATA  ? 7'd64 : 7'd0;
    endfunction
endpackage

// File: rtl/usb_bit_counter.sv
// usb_bit_counter: 7-bit decoded-bit counter with clear, enable and terminal-count hit
module usb_bit_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [6:0] i_term,
    output logic       o_hit
);
    logic [6:0] r_count;

    assign o_hit = i_enable && (r_count == i_term - 7'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable)
            r_count <= r_count + 7'd1;
    end
endmodule

// File: rtl/usb_rcv_ctrl.sv
// usb_rcv_ctrl: USB packet receive FSM (sync/PID check, field strobes, EOP, error)
// Define USB_RCV_TIMEOUT_EN to enable the receive watchdog (TIMEOUT_CYCLES clocks without a bit).
module usb_rcv_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_d_edge,
    input  logic       i_shift_enable,
    input  logic       i_eop,
    input  logic [7:0] i_rcv_byte,
    output logic       o_sync_shift,
    output logic       o_pid_shift,
    output logic       o_crc5_shift,
    output logic       o_crc16_shift,
    output logic       o_data_shift,
    output logic       o_rcving,
    output logic [1:0] o_pkt_type,
    output logic       o_packet_done,
    output logic       o_r_error
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("usb_rcv_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_t r_state;
    state_t w_next;
    pkt_t   r_pkt_type;
    logic   r_packet_done;
    logic   r_error;
    logic   r_eop_seen;
    logic   w_field;
    logic   w_shift;
    logic   w_hit;
    logic   w_timeout;
    logic   w_abort;

    assign w_field = r_state inside {S_SYNC, S_PID, S_CRC5, S_CRC16, S_DATA};
    // eop wins over a same-cycle bit: that bit is neither counted nor strobed
    assign w_shift = i_shift_enable && !i_eop;
    assign w_abort = i_eop || w_timeout;

    usb_bit_counter u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_field || w_hit),
        .i_enable (w_shift && w_field),
        .i_term   (field_bits(r_state)),
        .o_hit    (w_hit)
    );

`ifdef USB_RCV_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [IW-1:0] r_idle;
    logic          w_watch;

    assign w_watch   = w_field || r_state == S_WAIT_EOP;
    assign w_timeout = w_watch && !i_shift_enable && r_idle == IW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_idle <= '0;
        else if (!w_watch || i_shift_enable)
            r_idle <= '0;
        else
            r_idle <= r_idle + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = i_d_edge ? S_SYNC : S_IDLE;
            S_SYNC:     w_next = w_abort ? S_ERR : w_hit ? S_CHK_SYNC : S_SYNC;
            S_CHK_SYNC: w_next = (i_eop || i_rcv_byte != SYNC_BYTE) ? S_ERR : S_PID;
            S_PID:      w_next = w_abort ? S_ERR : w_hit ? S_CHK_PID : S_PID;
            S_CHK_PID:  w_next = i_eop ? S_ERR :
                                 pid_class(i_rcv_byte) == PKT_TOKEN ? S_CRC5 :
                                 pid_class(i_rcv_byte) == PKT_DATA  ? S_CRC16 :
                                 pid_class(i_rcv_byte) == PKT_HS    ? S_WAIT_EOP : S_ERR;
            S_CRC5:     w_next = w_abort ? S_ERR : w_hit ? S_WAIT_EOP : S_CRC5;
            S_CRC16:    w_next = w_abort ? S_ERR : w_hit ? S_DATA : S_CRC16;
            S_DATA:     w_next = w_abort ? S_ERR : w_hit ? S_WAIT_EOP : S_DATA;
            S_WAIT_EOP: w_next = i_eop ? S_DONE : (i_shift_enable || w_timeout) ? S_ERR : S_WAIT_EOP;
            S_DONE:     w_next = i_eop ? S_DONE : S_IDLE;
            S_ERR:      w_next = (!i_eop && r_eop_seen) ? S_IDLE : S_ERR;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pkt_type    <= PKT_NONE;
            r_packet_done <= 1'b0;
            r_error       <= 1'b0;
            r_eop_seen    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_packet_done <= r_state == S_WAIT_EOP && w_next == S_DONE;
            if (r_state == S_CHK_PID)
                r_pkt_type <= pid_class(i_rcv_byte);
            if (r_state == S_IDLE && i_d_edge)
                r_error <= 1'b0;
            else if (w_next == S_ERR)
                r_error <= 1'b1;
            // leaving ERR needs an eop high phase followed by eop low
            if (r_state != S_ERR)
                r_eop_seen <= i_eop;
            else if (i_eop)
                r_eop_seen <= 1'b1;
        end
    end

    assign o_sync_shift  = w_shift && r_state == S_SYNC;
    assign o_pid_shift   = w_shift && r_state == S_PID;
    assign o_crc5_shift  = w_shift && r_state == S_CRC5;
    assign o_crc16_shift = w_shift && r_state == S_CRC16;
    assign o_data_shift  = w_shift && r_state == S_DATA;
    assign o_rcving      = r_state != S_IDLE && r_state != S_ERR;
    assign o_pkt_type    = r_pkt_type;
    assign o_packet_done = r_packet_done;
    assign o_r_error     = r_error;
endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// tb_usb_rcv_ctrl: directed self-checking bench for usb_rcv_ctrl (honours USB_RCV_TIMEOUT_EN)
module tb_usb_rcv_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       shift_enable = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] rcv_byte = 8'h00;
    logic       sync_shift, pid_shift, crc5_shift, crc16_shift, data_shift;
    logic       rcving, packet_done, r_error;
    logic [1:0] pkt_type;
    logic       cnt_clr = 1'b0;
    int         n_sync, n_pid, n_crc5, n_crc16, n_data, n_done;
    int         n_vec = 0;
    int         n_err = 0;

    usb_rcv_ctrl #(.TIMEOUT_CYCLES(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_d_edge      (d_edge),
        .i_shift_enable(shift_enable),
        .i_eop         (eop),
        .i_rcv_byte    (rcv_byte),
        .o_sync_shift  (sync_shift),
        .o_pid_shift   (pid_shift),
        .o_crc5_shift  (crc5_shift),
        .o_crc16_shift (crc16_shift),
        .o_data_shift  (data_shift),
        .o_rcving      (rcving),
        .o_pkt_type    (pkt_type),
        .o_packet_done (packet_done),
        .o_r_error     (r_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clr) begin
            n_sync <= 0; n_pid <= 0; n_crc5 <= 0; n_crc16 <= 0; n_data <= 0; n_done <= 0;
        end else begin
            n_sync  <= n_sync  + int'(sync_shift);
            n_pid   <= n_pid   + int'(pid_shift);
            n_crc5  <= n_crc5  + int'(crc5_shift);
            n_crc16 <= n_crc16 + int'(crc16_shift);
            n_data  <= n_data  + int'(data_shift);
            n_done  <= n_done  + int'(packet_done);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bits(input int n, input logic [7:0] b);
        rcv_byte = b;
        repeat (n) begin
            shift_enable = 1'b1; tick();
            shift_enable = 1'b0; tick();
        end
    endtask

    task automatic start_pkt();
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        d_edge = 1'b1; tick();
        d_edge = 1'b0;
    endtask

    task automatic end_eop();
        eop = 1'b1; tick(); tick();
        eop = 1'b0; tick(); tick();
    endtask

    function automatic logic [9:0] all_out();
        return {sync_shift, pid_shift, crc5_shift, crc16_shift, data_shift,
                rcving, pkt_type, packet_done, r_error};
    endfunction

    initial begin
        #1;
        check("reset_outputs", 32'(all_out()), 0);
        tick(); tick();
        rst = 1'b0; tick();
        check("idle_rcving", 32'(rcving), 0);

        // token
        start_pkt();
        check("tok_rcving", 32'(rcving), 1);
        bits(8, 8'h80); bits(8, 8'h96); bits(5, 8'h00);
        check("tok_rcving_wait", 32'(rcving), 1);
        end_eop();
        check("tok_type", 32'(pkt_type), 1);
        check("tok_sync_n", n_sync, 8);
        check("tok_pid_n", n_pid, 8);
        check("tok_crc5_n", n_crc5, 5);
        check("tok_crc16_n", n_crc16, 0);
        check("tok_done_n", n_done, 1);
        check("tok_error", 32'(r_error), 0);
        check("tok_idle", 32'(rcving), 0);

        // data
        start_pkt();
        bits(8, 8'h80); bits(8, 8'h3C); bits(16, 8'h00);
        check("dat_crc16_n", n_crc16, 16);
        check("dat_data_mid", n_data, 0);
        bits(64, 8'h00);
        end_eop();
        check("dat_type", 32'(pkt_type), 2);
        check("dat_data_n", n_data, 64);
        check("dat_crc5_n", n_crc5, 0);
        check("dat_done_n", n_done, 1);
        check("dat_error", 32'(r_error), 0);

        // handshake
        start_pkt();
        bits(8, 8'h80); bits(8, 8'h2D);
        end_eop();
        check("hs_type", 32'(pkt_type), 3);
        check("hs_strobes", n_crc5 + n_crc16 + n_data, 0);
        check("hs_done_n", n_done, 1);

        // bad sync, then recovery clears the error on d_edge
        start_pkt();
        bits(8, 8'h00);
        check("bsync_error", 32'(r_error), 1);
        check("bsync_rcving", 32'(rcving), 0);
        bits(8, 8'h2D);
        check("bsync_no_pid", n_pid, 0);
        end_eop();
        check("bsync_done_n", n_done, 0);
        check("bsync_sticky", 32'(r_error), 1);
        start_pkt();
        check("recover_clear", 32'(r_error), 0);
        bits(8, 8'h80); bits(8, 8'h2D);
        end_eop();
        check("recover_done", n_done, 1);

        // unknown PID
        start_pkt();
        bits(8, 8'h80); bits(8, 8'hFF);
        check("bpid_error", 32'(r_error), 1);
        check("bpid_rcving", 32'(rcving), 0);
        check("bpid_type", 32'(pkt_type), 0);
        end_eop();
        check("bpid_done_n", n_done, 0);

        // eop after 30 data bits
        start_pkt();
        bits(8, 8'h80); bits(8, 8'h3C); bits(16, 8'h00); bits(30, 8'h00);
        end_eop();
        check("short_error", 32'(r_error), 1);
        check("short_data_n", n_data, 30);
        check("short_done_n", n_done, 0);

        // shift_enable and eop together in CRC5
        start_pkt();
        bits(8, 8'h80); bits(8, 8'h96);
        shift_enable = 1'b1; eop = 1'b1; #1;
        check("se_eop_strobe", 32'(crc5_shift), 0);
        tick();
        shift_enable = 1'b0;
        check("se_eop_error", 32'(r_error), 1);
        eop = 1'b0; tick(); tick();
        check("se_eop_crc5_n", n_crc5, 0);
        check("se_eop_idle", 32'(rcving), 0);

        // reset during CRC16
        start_pkt();
        bits(8, 8'h80); bits(8, 8'h3C); bits(5, 8'h00);
        shift_enable = 1'b1; #1;
        check("crc16_strobe", 32'(crc16_shift), 1);
        rst = 1'b1; #1;
        check("rst_mid_outputs", 32'(all_out()), 0);
        shift_enable = 1'b0; tick();
        rst = 1'b0; tick(); tick(); tick();
        check("rst_waits_idle", 32'(rcving), 0);
        check("rst_no_error", 32'(r_error), 0);

        // stalled PID field
        start_pkt();
        bits(8, 8'h80); bits(3, 8'h2D);
        repeat (40) tick();
`ifdef USB_RCV_TIMEOUT_EN
        check("stall_error", 32'(r_error), 1);
        check("stall_rcving", 32'(rcving), 0);
`else
        check("stall_error", 32'(r_error), 0);
        check("stall_rcving", 32'(rcving), 1);
`endif
        end_eop();
        check("stall_exit", 32'(rcving), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
